// File: rtl/mac_pipeline.sv
// Pipelined signed fixed-point multiply-accumulate unit: streams (input_data, weight) beats,
// accumulates first/last-delimited groups with a bias, and emits rounded, optionally saturated results.
module mac_pipeline #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int MUL_STAGES = 2,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] weight,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic                  input_weight_valid,
    input  logic                  first,
    input  logic                  last,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  seq_error
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [ACC_WIDTH:0] ROUND_HALF = (ACC_WIDTH+1)'(1) << (FRAC_BITS - 1);

    logic signed [2*DATA_WIDTH-1:0] product_full;
    logic signed [ACC_WIDTH-1:0]    product_ext;

    assign product_full = $signed(input_data) * $signed(weight);
    assign product_ext  = ACC_WIDTH'(product_full);

    // Each stage owns its registers; the product travels with its flags and bias.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
            logic                        valid_in, first_in, last_in;
            logic signed [ACC_WIDTH-1:0] prod_in;
            logic [DATA_WIDTH-1:0]       bias_in;
            logic                        valid_q, first_q, last_q;
            logic signed [ACC_WIDTH-1:0] prod_q;
            logic [DATA_WIDTH-1:0]       bias_q;

            if (gi == 0) begin : g_src
                assign valid_in = input_weight_valid;
                assign first_in = first;
                assign last_in  = last;
                assign prod_in  = product_ext;
                assign bias_in  = bias;
            end else begin : g_src
                assign valid_in = g_stage[gi-1].valid_q;
                assign first_in = g_stage[gi-1].first_q;
                assign last_in  = g_stage[gi-1].last_q;
                assign prod_in  = g_stage[gi-1].prod_q;
                assign bias_in  = g_stage[gi-1].bias_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_in;
                end
                first_q <= first_in;
                last_q  <= last_in;
                prod_q  <= prod_in;
                bias_q  <= bias_in;
            end
        end
    endgenerate

    logic                        mul_valid, mul_first, mul_last;
    logic signed [ACC_WIDTH-1:0] mul_prod;
    logic [DATA_WIDTH-1:0]       mul_bias;
    logic signed [ACC_WIDTH-1:0] bias_shifted;

    assign mul_valid    = g_stage[MUL_STAGES-1].valid_q;
    assign mul_first    = g_stage[MUL_STAGES-1].first_q;
    assign mul_last     = g_stage[MUL_STAGES-1].last_q;
    assign mul_prod     = g_stage[MUL_STAGES-1].prod_q;
    assign mul_bias     = g_stage[MUL_STAGES-1].bias_q;
    assign bias_shifted = ACC_WIDTH'($signed(mul_bias)) <<< FRAC_BITS;

    state_t                      state_reg, state_next;
    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic                        emit_reg, emit_next;
    logic                        seq_error_next;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        emit_next      = 1'b0;
        seq_error_next = 1'b0;
        if (mul_valid) begin
            // A non-first beat in IDLE is promoted to a group start.
            if (mul_first || state_reg == IDLE) begin
                acc_next = bias_shifted + mul_prod;
            end else begin
                acc_next = acc_reg + mul_prod;
            end
            seq_error_next = (state_reg == IDLE) ? !mul_first : mul_first;
            state_next     = mul_last ? IDLE : ACCUM;
            emit_next      = mul_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            emit_reg  <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            emit_reg  <= emit_next;
            seq_error <= seq_error_next;
        end
    end

    // One guard bit keeps the rounding add from wrapping.
    logic signed [ACC_WIDTH:0] rounded;
    logic signed [ACC_WIDTH:0] scaled;
    logic                      fits;
    logic [DATA_WIDTH-1:0]     clipped;

    assign rounded = $signed({acc_reg[ACC_WIDTH-1], acc_reg}) + $signed(ROUND_HALF);
    assign scaled  = rounded >>> FRAC_BITS;
    assign fits    = (&scaled[ACC_WIDTH:DATA_WIDTH-1]) | ~(|scaled[ACC_WIDTH:DATA_WIDTH-1]);
    assign clipped = scaled[ACC_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= emit_reg;
            overflow     <= emit_reg && !fits;
            if (emit_reg) begin
                result <= (SATURATE != 0 && !fits) ? clipped : scaled[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mac_pipeline.sv
// Directed bench for mac_pipeline: a saturating and a wrapping instance share one stimulus stream.
module tb_mac_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] input_data, weight, bias;
    logic        input_weight_valid, first, last;
    logic [15:0] result, result_w;
    logic        result_valid, overflow, seq_error;
    logic        result_valid_w, overflow_w, seq_error_w;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mac_pipeline #(.SATURATE(1)) dut (
        .clk(clk), .reset(reset), .input_data(input_data), .weight(weight), .bias(bias),
        .input_weight_valid(input_weight_valid), .first(first), .last(last),
        .result(result), .result_valid(result_valid), .overflow(overflow), .seq_error(seq_error)
    );

    mac_pipeline #(.SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .input_data(input_data), .weight(weight), .bias(bias),
        .input_weight_valid(input_weight_valid), .first(first), .last(last),
        .result(result_w), .result_valid(result_valid_w), .overflow(overflow_w),
        .seq_error(seq_error_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic beat(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b,
                        input logic f, input logic l);
        input_data         = d;
        weight             = w;
        bias               = b;
        first              = f;
        last               = l;
        input_weight_valid = 1'b1;
        tick();
        $display("beat d=%h w=%h b=%h first=%0b last=%0b", d, w, b, f, l);
    endtask

    task automatic idle(input int n);
        input_weight_valid = 1'b0;
        first              = 1'b0;
        last               = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_result(input string tag, input int budget);
        input_weight_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (result_valid) break;
        end
        chk({tag, "_arrive"}, result_valid, 1'b1);
        $display("result %s = %h ovf=%0b (wrap %h ovf=%0b)", tag, result, overflow,
                 result_w, overflow_w);
    endtask

    initial begin
        reset = 1'b1;
        input_data = '0; weight = '0; bias = '0;
        input_weight_valid = 1'b0; first = 1'b0; last = 1'b0;
        repeat (2) tick();
        chk("rst_result", result, 16'h0000);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_seqerr", seq_error, 1'b0);
        reset = 1'b0;
        tick();

        // 1.5 x 2.0, single-term group, exact latency
        beat(16'h0180, 16'h0200, 16'h0000, 1'b1, 1'b1);
        idle(1); chk("t1_valid_e1", result_valid, 1'b0);
        idle(1); chk("t1_valid_e2", result_valid, 1'b0);
        idle(1); chk("t1_valid_e3", result_valid, 1'b1);
        chk("t1_result", result, 16'h0300);
        chk("t1_ovf", overflow, 1'b0);
        idle(1); chk("t1_pulse", result_valid, 1'b0);
        chk("t1_hold", result, 16'h0300);

        // 0.5 + 1.0 + 1.0 - 3.0 = -0.5 with a bubble before the last beat
        beat(16'h0100, 16'h0100, 16'h0080, 1'b1, 1'b0);
        beat(16'h0200, 16'h0080, 16'h0000, 1'b0, 1'b0);
        idle(1);
        beat(16'hFE80, 16'h0200, 16'h0000, 1'b0, 1'b1);
        idle(1); chk("t2_valid_e1", result_valid, 1'b0);
        idle(1); chk("t2_valid_e2", result_valid, 1'b0);
        idle(1); chk("t2_valid_e3", result_valid, 1'b1);
        chk("t2_result", result, 16'hFF80);
        chk("t2_seqerr", seq_error, 1'b0);

        // rounding half toward +inf
        beat(16'h0001, 16'h0080, 16'h0000, 1'b1, 1'b1);
        wait_result("t3a", 6);
        chk("t3a_result", result, 16'h0001);
        chk("t3a_ovf", overflow, 1'b0);
        beat(16'hFFFF, 16'h0080, 16'h0000, 1'b1, 1'b1);
        wait_result("t3b", 6);
        chk("t3b_result", result, 16'h0000);
        chk("t3b_ovf", overflow, 1'b0);

        // positive and negative overflow; wrap instance keeps the low 16 bits of s
        beat(16'h7F00, 16'h7F00, 16'h0000, 1'b1, 1'b1);
        wait_result("t4a", 6);
        chk("t4a_result", result, 16'h7FFF);
        chk("t4a_ovf", overflow, 1'b1);
        chk("t4a_wrap_result", result_w, 16'h0100);
        chk("t4a_wrap_ovf", overflow_w, 1'b1);
        beat(16'h8000, 16'h7F00, 16'h0000, 1'b1, 1'b1);
        wait_result("t4b", 6);
        chk("t4b_result", result, 16'h8000);
        chk("t4b_ovf", overflow, 1'b1);
        chk("t4b_wrap_result", result_w, 16'h8000);
        chk("t4b_wrap_ovf", overflow_w, 1'b1);
        idle(1); chk("t4_ovf_low", overflow, 1'b0);

        // first=0 while idle: promoted to first, bias 1.0 + 1.0
        beat(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1);
        idle(1); chk("t5a_seqerr_e1", seq_error, 1'b0);
        idle(1); chk("t5a_seqerr_e2", seq_error, 1'b1);
        idle(1); chk("t5a_seqerr_e3", seq_error, 1'b0);
        chk("t5a_valid", result_valid, 1'b1);
        chk("t5a_result", result, 16'h0200);

        // first=1 mid-group: restart with bias 1.0 + 2.0
        beat(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        beat(16'h0200, 16'h0100, 16'h0100, 1'b1, 1'b1);
        idle(1); chk("t5b_seqerr_e1", seq_error, 1'b0);
        idle(1); chk("t5b_seqerr_e2", seq_error, 1'b1);
        idle(1); chk("t5b_valid", result_valid, 1'b1);
        chk("t5b_result", result, 16'h0300);

        // back-to-back single-term groups
        beat(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        beat(16'h0200, 16'h0100, 16'h0000, 1'b1, 1'b1);
        idle(2);
        chk("bb_valid0", result_valid, 1'b1);
        chk("bb_result0", result, 16'h0100);
        idle(1);
        chk("bb_valid1", result_valid, 1'b1);
        chk("bb_result1", result, 16'h0200);

        // reset with a complete group in flight
        beat(16'h0180, 16'h0200, 16'h0000, 1'b1, 1'b1);
        input_weight_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_result", result, 16'h0000);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_seqerr", seq_error, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_valid", result_valid, 1'b0);
        end
        beat(16'h0180, 16'h0200, 16'h0000, 1'b1, 1'b1);
        idle(2); chk("t6_rerun_e2", result_valid, 1'b0);
        idle(1); chk("t6_rerun_e3", result_valid, 1'b1);
        chk("t6_rerun_result", result, 16'h0300);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
